// File: rtl/key_input_regs.sv
// key_input_regs: synchronised, debounced pushbuttons exposed as level / W1C event / press-counter registers.
// Define KEY_RELEASE_EVT_EN to also latch release events into reg0x7401[8+NK-1:8].
module key_input_regs #(
    parameter int AW        = 15,
    parameter int DW        = 16,
    parameter int NK        = 4,
    parameter int DB_CYCLES = 500000
) (
    input  logic          clk50m,
    input  logic          rst_n,
    input  logic [NK-1:0] keys_n,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] reg0x7400,
    output logic [DW-1:0] reg0x7401,
    output logic [DW-1:0] reg0x7402
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [NK-1:0] sync1, sync2, level, pressed_s, accept, press_evt;
    logic [CW-1:0] cnt [NK];
    logic [DW-1:0] evt, n_press;
    logic          wr_flags, wr_count;
    assign pressed_s = ~sync2;
    assign wr_flags  = we && addr == AW'(16'h7401);
    assign wr_count  = we && addr == AW'(16'h7402);
    assign reg0x7400 = DW'(level);
`ifdef KEY_RELEASE_EVT_EN
    logic [NK-1:0] release_evt;
    assign release_evt = accept & ~pressed_s;
`endif
    // Events strobe on the acceptance cycle so flags, counter and level all update on the same edge.
    always_comb begin
        accept    = '0;
        press_evt = '0;
        n_press   = '0;
        evt       = '0;
        for (int k = 0; k < NK; k++) begin
            accept[k]    = pressed_s[k] != level[k] && cnt[k] == CW'(DB_CYCLES - 1);
            press_evt[k] = accept[k] & pressed_s[k];
            n_press      = n_press + DW'(press_evt[k]);
        end
        evt[NK-1:0] = press_evt;
`ifdef KEY_RELEASE_EVT_EN
        evt[8+NK-1:8] = release_evt;
`endif
    end
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '1;
            sync2     <= '1;
            level     <= '0;
            reg0x7401 <= '0;
            reg0x7402 <= '0;
            for (int k = 0; k < NK; k++) cnt[k] <= '0;
        end else begin
            sync1 <= keys_n;
            sync2 <= sync1;
            for (int k = 0; k < NK; k++) begin
                if (pressed_s[k] == level[k]) cnt[k] <= '0;
                else if (accept[k]) begin
                    level[k] <= pressed_s[k];
                    cnt[k]   <= '0;
                end else cnt[k] <= cnt[k] + 1'b1;
            end
            reg0x7401 <= (reg0x7401 & ~(wr_flags ? data_in : '0)) | evt;
            reg0x7402 <= (wr_count ? data_in : reg0x7402) + n_press;
        end
    end
endmodule
